pipe_hazard_fwd: RTL and testbench
==================================

PIPE_HAZARD_FWD -- requirements
Module: pipe_hazard_fwd

Interface
Parameters: none.
- REQ-001 SHALL have port `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- REQ-002 SHALL have port `reset`: input, 1 bit. Reset is synchronous and active-low.
- REQ-003 SHALL have port `WB_MemtoReg_ex`: input, 2 bits. Write-back source select of the EX instruction.
- REQ-004 SHALL have ports `WB_RegWrite_ex`, `MEM_MemWrite_ex`, `MEM_MemRead_ex`: inputs, 1 bit each. EX-stage control bits.
- REQ-005 SHALL have port `RegWriteAddress_ex`: input, 5 bits. EX destination register.
- REQ-006 SHALL have ports `PC_ex`, `ALU_out`, `RealOut2`: inputs, 32 bits each. EX PC, ALU result, forwarded rt data.
- REQ-007 SHALL have ports `RsAddress_ex`, `RtAddress_ex`, `RsAddress_id`, `RtAddress_id`: inputs, 5 bits each. Source register numbers.
- REQ-008 SHALL have ports `WB_RegWrite_wb` (input, 1 bit) and `RegWriteAddress_wb` (input, 5 bits). WB-stage write info.
- REQ-009 SHALL have ports `Whether_branch`, `Whether_jump`: inputs, 1 bit each. Taken branch / jump decoded in ID.
- REQ-010 SHALL have outputs `WB_MemtoReg_mem` (2 bits) and `WB_RegWrite_mem`, `MEM_MemWrite_mem`, `MEM_MemRead_mem` (1 bit each). Registered controls.
- REQ-011 SHALL have outputs `RegWriteAddress_mem` (5 bits) and `PC_mem`, `ALUResult_mem`, `MemWriteData_mem` (32 bits each). Registered data.
- REQ-012 SHALL have outputs `ForwardA`, `ForwardB`: 2 bits each. EX ALU operand selects for rs/rt.
- REQ-013 SHALL have outputs `ForwardC`, `ForwardD`: 2 bits each. ID branch-compare selects for rs/rt.
- REQ-014 SHALL have outputs `Keep_current_PC`, `IF_ID_keep`, `stall`, `flush`: 1 bit each. Pipeline control.

Function
- REQ-015 SHALL capture every `*_ex` input and `ALU_out`/`RealOut2` into the matching `*_mem` output each rising edge when `reset`=1, with 1-cycle latency:
  - `ALU_out` -> `ALUResult_mem`
  - `RealOut2` -> `MemWriteData_mem`
- REQ-016 SHALL compute `ForwardA` combinationally, in priority order:
  - 2'b10 if `WB_RegWrite_mem` && `RegWriteAddress_mem`!=0 && `RegWriteAddress_mem`==`RsAddress_ex`;
  - else 2'b01 if the same test passes using the WB write info;
  - else 2'b00.
- REQ-017 SHALL compute `ForwardB` identically to `ForwardA`, using `RtAddress_ex`.
- REQ-018 SHALL compute `ForwardC` combinationally, in priority order:
  - 2'b10 if `WB_RegWrite_ex` && `RegWriteAddress_ex`!=0 && `RegWriteAddress_ex`==`RsAddress_id`;
  - else 2'b01 if the same test passes using the MEM write info;
  - else 2'b00.
- REQ-019 SHALL compute `ForwardD` identically to `ForwardC`, using `RtAddress_id`.
- REQ-020 SHALL never output 2'b11 on any Forward select.
- REQ-021 SHALL assert `stall`, `Keep_current_PC` and `IF_ID_keep` (all equal) when all of the following hold:
  - `MEM_MemRead_ex`=1;
  - `RtAddress_ex`!=0;
  - `RtAddress_ex`==`RsAddress_id` or `RtAddress_ex`==`RtAddress_id`.
- REQ-022 SHALL assert `flush` when (`Whether_branch` || `Whether_jump`) && !`stall`; on simultaneous stall and branch/jump, the stall wins.
- REQ-023 SHALL drive `stall`, `Keep_current_PC`, `IF_ID_keep` and `flush` to 0 while `reset`=0.
- REQ-024 SHALL make all forward/hazard outputs purely combinational (no state, zero latency).

Reset
- REQ-025 SHALL clear every `*_mem` output to 0 on a rising edge with `reset`=0.
- REQ-026 SHALL give `reset` priority over the capture in REQ-015; reset asserted mid-operation discards the in-flight EX instruction.

Structure
- REQ-027 SHALL place the forward-select encodings in a shared package:
  - FWD_REG=2'b00;
  - EX path: FWD_WB=2'b01, FWD_MEM=2'b10;
  - ID path: FWDID_MEM=2'b01, FWDID_EX=2'b10.
- REQ-028 SHALL implement the EX/MEM register as one sub-module `ex_mem_reg`, with forwarding and hazard logic as combinational code in the top.

Verification
- REQ-029 SHALL check reset: `reset`=0 for one edge with nonzero inputs -> all `*_mem` outputs 0; `stall`=`flush`=0.
- REQ-030 SHALL check capture: `ALU_out`=0x1234, `RegWriteAddress_ex`=5, `WB_RegWrite_ex`=1 -> next edge `ALUResult_mem`=0x1234, `RegWriteAddress_mem`=5.
- REQ-031 SHALL check EX forwarding priority: MEM and WB both write reg 8, `RsAddress_ex`=8 -> `ForwardA`=2'b10; MEM write disabled -> 2'b01; reg 0 -> 2'b00.
- REQ-032 SHALL check ID forwarding: `WB_RegWrite_ex`=1, `RegWriteAddress_ex`=9, `RtAddress_id`=9 -> `ForwardD`=2'b10; EX write off, MEM writes 9 -> 2'b01.
- REQ-033 SHALL check load-use: `MEM_MemRead_ex`=1, `RtAddress_ex`=3, `RsAddress_id`=3 -> `stall`=`Keep_current_PC`=`IF_ID_keep`=1; adding `Whether_jump`=1 -> `flush`=0.
- REQ-034 SHALL check flush: `Whether_branch`=1, no load-use -> `flush`=1, `stall`=0.

Source files
------------

// File: rtl/pipe_hazard_fwd_pkg.sv
// Shared encodings and types for the EX/MEM register and the forwarding/hazard unit.
package pipe_hazard_fwd_pkg;

  // Operand-select encodings. EX path picks between the MEM and WB stages;
  // ID path (branch compare) picks between the EX and MEM stages.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWDID_MEM = 2'b01;
  localparam logic [1:0] FWDID_EX  = 2'b10;

  // Everything the EX stage hands over to the MEM stage.
  typedef struct packed {
    logic [1:0]  memtoreg;
    logic        regwrite;
    logic        memwrite;
    logic        memread;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wdata;
  } ex_mem_t;

  // A producer stage can supply a source register only if it really writes,
  // the destination is not the hard-wired zero register, and the numbers match.
  function automatic logic fwd_hit(input logic we, input logic [4:0] waddr,
                                   input logic [4:0] raddr);
    return we && (waddr != 5'd0) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/pipe_hazard_fwd_if.sv
// Pipeline-side bundle of the hazard/forwarding block; names follow the datapath.
interface pipe_hazard_fwd_if;
  logic [1:0]  WB_MemtoReg_ex;
  logic        WB_RegWrite_ex;
  logic        MEM_MemWrite_ex;
  logic        MEM_MemRead_ex;
  logic [4:0]  RegWriteAddress_ex;
  logic [31:0] PC_ex;
  logic [31:0] ALU_out;
  logic [31:0] RealOut2;
  logic [4:0]  RsAddress_ex;
  logic [4:0]  RtAddress_ex;
  logic [4:0]  RsAddress_id;
  logic [4:0]  RtAddress_id;
  logic        WB_RegWrite_wb;
  logic [4:0]  RegWriteAddress_wb;
  logic        Whether_branch;
  logic        Whether_jump;

  logic [1:0]  WB_MemtoReg_mem;
  logic        WB_RegWrite_mem;
  logic        MEM_MemWrite_mem;
  logic        MEM_MemRead_mem;
  logic [4:0]  RegWriteAddress_mem;
  logic [31:0] PC_mem;
  logic [31:0] ALUResult_mem;
  logic [31:0] MemWriteData_mem;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [1:0]  ForwardC;
  logic [1:0]  ForwardD;
  logic        Keep_current_PC;
  logic        IF_ID_keep;
  logic        stall;
  logic        flush;

  modport slave (
    input  WB_MemtoReg_ex, WB_RegWrite_ex, MEM_MemWrite_ex, MEM_MemRead_ex,
           RegWriteAddress_ex, PC_ex, ALU_out, RealOut2,
           RsAddress_ex, RtAddress_ex, RsAddress_id, RtAddress_id,
           WB_RegWrite_wb, RegWriteAddress_wb, Whether_branch, Whether_jump,
    output WB_MemtoReg_mem, WB_RegWrite_mem, MEM_MemWrite_mem, MEM_MemRead_mem,
           RegWriteAddress_mem, PC_mem, ALUResult_mem, MemWriteData_mem,
           ForwardA, ForwardB, ForwardC, ForwardD,
           Keep_current_PC, IF_ID_keep, stall, flush
  );

  modport master (
    output WB_MemtoReg_ex, WB_RegWrite_ex, MEM_MemWrite_ex, MEM_MemRead_ex,
           RegWriteAddress_ex, PC_ex, ALU_out, RealOut2,
           RsAddress_ex, RtAddress_ex, RsAddress_id, RtAddress_id,
           WB_RegWrite_wb, RegWriteAddress_wb, Whether_branch, Whether_jump,
    input  WB_MemtoReg_mem, WB_RegWrite_mem, MEM_MemWrite_mem, MEM_MemRead_mem,
           RegWriteAddress_mem, PC_mem, ALUResult_mem, MemWriteData_mem,
           ForwardA, ForwardB, ForwardC, ForwardD,
           Keep_current_PC, IF_ID_keep, stall, flush
  );
endinterface

// File: rtl/pipe_hazard_fwd_ex_mem_reg.sv
// EX/MEM pipeline register; reset clears the stage and discards the EX instruction.
module ex_mem_reg
  import pipe_hazard_fwd_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  ex_mem_t ex_i,
  output ex_mem_t mem_o
);

  ex_mem_t mem_q;
  ex_mem_t mem_d;

  // Next state: capture EX, or a cleared bubble while reset is low.
  always_comb begin
    mem_d = '0;
    if (reset) begin
      mem_d = ex_i;
    end
  end

  // Stage register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign mem_o = mem_q;

endmodule

// File: rtl/pipe_hazard_fwd.sv
// EX/MEM register plus combinational forwarding selects and load-use / control hazard logic.
module pipe_hazard_fwd
  import pipe_hazard_fwd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  pipe_hazard_fwd_if.slave bus
);

  ex_mem_t ex_w;
  ex_mem_t mem_w;
  logic    load_use;

  assign ex_w.memtoreg = bus.WB_MemtoReg_ex;
  assign ex_w.regwrite = bus.WB_RegWrite_ex;
  assign ex_w.memwrite = bus.MEM_MemWrite_ex;
  assign ex_w.memread  = bus.MEM_MemRead_ex;
  assign ex_w.waddr    = bus.RegWriteAddress_ex;
  assign ex_w.pc       = bus.PC_ex;
  assign ex_w.alu      = bus.ALU_out;
  assign ex_w.wdata    = bus.RealOut2;

  ex_mem_reg u_ex_mem (
    .clk   (clk),
    .reset (reset),
    .ex_i  (ex_w),
    .mem_o (mem_w)
  );

  assign bus.WB_MemtoReg_mem     = mem_w.memtoreg;
  assign bus.WB_RegWrite_mem     = mem_w.regwrite;
  assign bus.MEM_MemWrite_mem    = mem_w.memwrite;
  assign bus.MEM_MemRead_mem     = mem_w.memread;
  assign bus.RegWriteAddress_mem = mem_w.waddr;
  assign bus.PC_mem              = mem_w.pc;
  assign bus.ALUResult_mem       = mem_w.alu;
  assign bus.MemWriteData_mem    = mem_w.wdata;

  // Operand selects: the younger producer wins, so MEM beats WB for the EX ALU
  // and EX beats MEM for the ID branch compare. Only one code is ever chosen,
  // so 2'b11 cannot appear.
  always_comb begin
    bus.ForwardA = FWD_REG;
    bus.ForwardB = FWD_REG;
    bus.ForwardC = FWD_REG;
    bus.ForwardD = FWD_REG;
    if (fwd_hit(mem_w.regwrite, mem_w.waddr, bus.RsAddress_ex))
      bus.ForwardA = FWD_MEM;
    else if (fwd_hit(bus.WB_RegWrite_wb, bus.RegWriteAddress_wb, bus.RsAddress_ex))
      bus.ForwardA = FWD_WB;
    if (fwd_hit(mem_w.regwrite, mem_w.waddr, bus.RtAddress_ex))
      bus.ForwardB = FWD_MEM;
    else if (fwd_hit(bus.WB_RegWrite_wb, bus.RegWriteAddress_wb, bus.RtAddress_ex))
      bus.ForwardB = FWD_WB;
    if (fwd_hit(bus.WB_RegWrite_ex, bus.RegWriteAddress_ex, bus.RsAddress_id))
      bus.ForwardC = FWDID_EX;
    else if (fwd_hit(mem_w.regwrite, mem_w.waddr, bus.RsAddress_id))
      bus.ForwardC = FWDID_MEM;
    if (fwd_hit(bus.WB_RegWrite_ex, bus.RegWriteAddress_ex, bus.RtAddress_id))
      bus.ForwardD = FWDID_EX;
    else if (fwd_hit(mem_w.regwrite, mem_w.waddr, bus.RtAddress_id))
      bus.ForwardD = FWDID_MEM;
  end

  // Load-use stall freezes PC and IF/ID; a taken branch/jump flushes only when
  // the ID instruction is not being held back. Both are silenced during reset.
  always_comb begin
    load_use = bus.MEM_MemRead_ex && (bus.RtAddress_ex != 5'd0) &&
               ((bus.RtAddress_ex == bus.RsAddress_id) ||
                (bus.RtAddress_ex == bus.RtAddress_id));
    bus.stall           = reset && load_use;
    bus.Keep_current_PC = bus.stall;
    bus.IF_ID_keep      = bus.stall;
    bus.flush           = reset && (bus.Whether_branch || bus.Whether_jump) && !bus.stall;
  end

endmodule

// File: tb/tb_pipe_hazard_fwd.sv
// Self-checking bench: directed vector table, hand sequences, and random stimulus
// against a reference model of the EX/MEM stage and hazard rules.
module tb_pipe_hazard_fwd;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_mis;

  pipe_hazard_fwd_if bus ();

  pipe_hazard_fwd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MEM stage: whatever EX held at the edge, or nothing after a reset edge.
  logic [1:0]  m_mtr;
  logic        m_we, m_mw, m_mr;
  logic [4:0]  m_addr;
  logic [31:0] m_pc, m_alu, m_wd;

  always @(posedge clk) begin
    if (!reset) begin
      m_mtr = '0; m_we = 0; m_mw = 0; m_mr = 0; m_addr = '0; m_pc = '0; m_alu = '0; m_wd = '0;
    end else begin
      m_mtr = bus.WB_MemtoReg_ex; m_we = bus.WB_RegWrite_ex; m_mw = bus.MEM_MemWrite_ex;
      m_mr = bus.MEM_MemRead_ex; m_addr = bus.RegWriteAddress_ex; m_pc = bus.PC_ex;
      m_alu = bus.ALU_out; m_wd = bus.RealOut2;
    end
  end

  // Producers listed youngest first; the first one writing register r supplies it.
  function automatic logic [1:0] pick(input logic [4:0] r,
                                      input logic we0, input logic [4:0] a0, input logic [1:0] c0,
                                      input logic we1, input logic [4:0] a1, input logic [1:0] c1);
    logic        we[2];
    logic [4:0]  a[2];
    logic [1:0]  c[2];
    we[0] = we0; a[0] = a0; c[0] = c0;
    we[1] = we1; a[1] = a1; c[1] = c1;
    if (r == 5'd0) return 2'd0;
    for (int i = 0; i < 2; i++)
      if (we[i] && a[i] == r) return c[i];
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_hazard(input string tag, input logic es, input logic ef);
    chk({tag, " stall"}, 32'(bus.stall), 32'(es));
    chk({tag, " keep_pc"}, 32'(bus.Keep_current_PC), 32'(es));
    chk({tag, " if_id_keep"}, 32'(bus.IF_ID_keep), 32'(es));
    chk({tag, " flush"}, 32'(bus.flush), 32'(ef));
  endtask

  task automatic check_mem(input string tag);
    chk({tag, " ctrl_mem"},
        {27'd0, bus.WB_MemtoReg_mem, bus.WB_RegWrite_mem, bus.MEM_MemWrite_mem, bus.MEM_MemRead_mem},
        {27'd0, m_mtr, m_we, m_mw, m_mr});
    chk({tag, " waddr_mem"}, 32'(bus.RegWriteAddress_mem), 32'(m_addr));
    chk({tag, " pc_mem"}, bus.PC_mem, m_pc);
    chk({tag, " alu_mem"}, bus.ALUResult_mem, m_alu);
    chk({tag, " wdata_mem"}, bus.MemWriteData_mem, m_wd);
  endtask

  task automatic clear_inputs();
    bus.WB_MemtoReg_ex = '0; bus.WB_RegWrite_ex = 0; bus.MEM_MemWrite_ex = 0;
    bus.MEM_MemRead_ex = 0; bus.RegWriteAddress_ex = '0; bus.PC_ex = '0;
    bus.ALU_out = '0; bus.RealOut2 = '0; bus.RsAddress_ex = '0; bus.RtAddress_ex = '0;
    bus.RsAddress_id = '0; bus.RtAddress_id = '0; bus.WB_RegWrite_wb = 0;
    bus.RegWriteAddress_wb = '0; bus.Whether_branch = 0; bus.Whether_jump = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       pm_we;   logic [4:0] pm_addr;
    logic       ex_we;   logic [4:0] ex_addr; logic ex_rd;
    logic [4:0] rs_ex;   logic [4:0] rt_ex;
    logic       wb_we;   logic [4:0] wb_addr;
    logic [4:0] rs_id;   logic [4:0] rt_id;
    logic       br;      logic       jmp;
    logic [1:0] ea, eb, ec, ed;
    logic       es, ef;
  } vec_t;

  vec_t tbl[13];

  initial begin
    n_vec = 0;
    n_mis = 0;
    //          pm      ex         rs/rt_ex  wb     rs/rt_id br j  A  B  C  D  st fl
    tbl[0]  = '{1, 8,   0, 0, 0,   8, 0,     1, 8,  0, 0,    0, 0, 2, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 8,   0, 0, 0,   8, 0,     1, 8,  0, 0,    0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0,   0, 0, 0,   0, 0,     1, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0,   1, 9, 0,   0, 0,     0, 0,  0, 9,    0, 0, 0, 0, 0, 2, 0, 0};
    tbl[4]  = '{1, 9,   0, 9, 0,   0, 0,     0, 0,  0, 9,    0, 0, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{1, 9,   1, 9, 0,   0, 0,     0, 0,  9, 9,    0, 0, 0, 0, 2, 2, 0, 0};
    tbl[6]  = '{0, 0,   0, 0, 1,   0, 3,     0, 0,  3, 0,    0, 0, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 0,   0, 0, 1,   0, 3,     0, 0,  3, 0,    0, 1, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{0, 0,   0, 0, 0,   0, 3,     0, 0,  3, 0,    1, 0, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0,   0, 0, 1,   0, 0,     0, 0,  0, 0,    1, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0,   0, 0, 1,   0, 4,     0, 0,  1, 4,    0, 0, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{1, 6,   0, 0, 0,   6, 6,     1, 6,  0, 0,    0, 0, 2, 2, 0, 0, 0, 0};
    tbl[12] = '{0, 6,   0, 0, 0,   2, 6,     1, 6,  6, 2,    0, 0, 0, 1, 0, 0, 0, 0};

    clear_inputs();
    reset = 0;
    tick();
    tick();

    // Reset with busy nonzero inputs, including a load-use and a branch.
    bus.WB_MemtoReg_ex = 2'b11; bus.WB_RegWrite_ex = 1; bus.MEM_MemWrite_ex = 1;
    bus.MEM_MemRead_ex = 1; bus.RegWriteAddress_ex = 5'd7; bus.PC_ex = 32'h400;
    bus.ALU_out = 32'hdeadbeef; bus.RealOut2 = 32'hcafef00d;
    bus.RtAddress_ex = 5'd3; bus.RsAddress_id = 5'd3; bus.Whether_branch = 1;
    #1;
    check_hazard("rst_comb", 0, 0);
    tick();
    chk("rst alu_mem", bus.ALUResult_mem, 32'h0);
    chk("rst waddr_mem", 32'(bus.RegWriteAddress_mem), 32'h0);
    chk("rst pc_mem", bus.PC_mem, 32'h0);
    chk("rst wdata_mem", bus.MemWriteData_mem, 32'h0);
    chk("rst ctrl_mem",
        {28'd0, bus.WB_MemtoReg_mem, bus.WB_RegWrite_mem, bus.MEM_MemWrite_mem},
        32'h0);
    chk("rst memread_mem", 32'(bus.MEM_MemRead_mem), 32'h0);

    // Capture with one-cycle latency.
    clear_inputs();
    reset = 1;
    bus.ALU_out = 32'h1234; bus.RegWriteAddress_ex = 5'd5; bus.WB_RegWrite_ex = 1;
    #1;
    chk("cap before_edge", bus.ALUResult_mem, 32'h0);
    tick();
    chk("cap alu_mem", bus.ALUResult_mem, 32'h1234);
    chk("cap waddr_mem", 32'(bus.RegWriteAddress_mem), 32'd5);
    chk("cap regwrite_mem", 32'(bus.WB_RegWrite_mem), 32'd1);

    // Reset arriving mid-stream drops the in-flight EX instruction.
    bus.ALU_out = 32'h5555aaaa; bus.RegWriteAddress_ex = 5'd12;
    reset = 0;
    tick();
    chk("midrst alu_mem", bus.ALUResult_mem, 32'h0);
    chk("midrst waddr_mem", 32'(bus.RegWriteAddress_mem), 32'h0);
    reset = 1;

    // Directed vectors: preload MEM stage via one capture, then apply the ID/EX/WB view.
    for (int i = 0; i < 13; i++) begin
      clear_inputs();
      bus.WB_RegWrite_ex = tbl[i].pm_we;
      bus.RegWriteAddress_ex = tbl[i].pm_addr;
      tick();
      clear_inputs();
      bus.WB_RegWrite_ex = tbl[i].ex_we;     bus.RegWriteAddress_ex = tbl[i].ex_addr;
      bus.MEM_MemRead_ex = tbl[i].ex_rd;
      bus.RsAddress_ex = tbl[i].rs_ex;       bus.RtAddress_ex = tbl[i].rt_ex;
      bus.WB_RegWrite_wb = tbl[i].wb_we;     bus.RegWriteAddress_wb = tbl[i].wb_addr;
      bus.RsAddress_id = tbl[i].rs_id;       bus.RtAddress_id = tbl[i].rt_id;
      bus.Whether_branch = tbl[i].br;        bus.Whether_jump = tbl[i].jmp;
      #1;
      chk($sformatf("tbl%0d ForwardA", i), 32'(bus.ForwardA), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d ForwardB", i), 32'(bus.ForwardB), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d ForwardC", i), 32'(bus.ForwardC), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d ForwardD", i), 32'(bus.ForwardD), 32'(tbl[i].ed));
      check_hazard($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ef);
    end

    // Random traffic with small register numbers so hits are common.
    for (int n = 0; n < 400; n++) begin
      logic lu, es;
      reset = ($urandom_range(0, 15) != 0);
      bus.WB_MemtoReg_ex = 2'($urandom_range(0, 3));
      bus.WB_RegWrite_ex = 1'($urandom_range(0, 1));
      bus.MEM_MemWrite_ex = 1'($urandom_range(0, 1));
      bus.MEM_MemRead_ex = 1'($urandom_range(0, 1));
      bus.RegWriteAddress_ex = 5'($urandom_range(0, 7));
      bus.PC_ex = $urandom; bus.ALU_out = $urandom; bus.RealOut2 = $urandom;
      bus.RsAddress_ex = 5'($urandom_range(0, 7));
      bus.RtAddress_ex = 5'($urandom_range(0, 7));
      bus.RsAddress_id = 5'($urandom_range(0, 7));
      bus.RtAddress_id = 5'($urandom_range(0, 7));
      bus.WB_RegWrite_wb = 1'($urandom_range(0, 1));
      bus.RegWriteAddress_wb = 5'($urandom_range(0, 7));
      bus.Whether_branch = ($urandom_range(0, 3) == 0);
      bus.Whether_jump = ($urandom_range(0, 5) == 0);
      #1;
      chk("rnd ForwardA", 32'(bus.ForwardA),
          32'(pick(bus.RsAddress_ex, m_we, m_addr, 2'b10,
                   bus.WB_RegWrite_wb, bus.RegWriteAddress_wb, 2'b01)));
      chk("rnd ForwardB", 32'(bus.ForwardB),
          32'(pick(bus.RtAddress_ex, m_we, m_addr, 2'b10,
                   bus.WB_RegWrite_wb, bus.RegWriteAddress_wb, 2'b01)));
      chk("rnd ForwardC", 32'(bus.ForwardC),
          32'(pick(bus.RsAddress_id, bus.WB_RegWrite_ex, bus.RegWriteAddress_ex, 2'b10,
                   m_we, m_addr, 2'b01)));
      chk("rnd ForwardD", 32'(bus.ForwardD),
          32'(pick(bus.RtAddress_id, bus.WB_RegWrite_ex, bus.RegWriteAddress_ex, 2'b10,
                   m_we, m_addr, 2'b01)));
      lu = bus.MEM_MemRead_ex && bus.RtAddress_ex != 0 &&
           (bus.RtAddress_ex == bus.RsAddress_id || bus.RtAddress_ex == bus.RtAddress_id);
      es = reset && lu;
      check_hazard("rnd", es, reset && !es && (bus.Whether_branch || bus.Whether_jump));
      tick();
      check_mem("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
